// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - tick-driven two-street phase sequencer with pedestrian and emergency arbitration
//
// Purpose:
//   Sequences street A / street B green time: ARA -> AG -> AY -> ARB -> BG -> BY -> ARA.
//   Pedestrian pulses are latched until served at the entry of the green that
//   lets the pedestrian cross. A pending request can also cut the opposite
//   green short once its minimum green has elapsed. Emergency levels (A has
//   priority over B) either hold their own green or preempt the other green.
//   Every output is a register.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick       in   one-cycle 1 Hz pulse; all timing advances only on tick
//   ped_req_a  in   pulse, request to cross street A (served during B green)
//   ped_req_b  in   pulse, request to cross street B (served during A green)
//   emg_a      in   level, emergency vehicle on street A
//   emg_b      in   level, emergency vehicle on street B
//   street_a   out  {red,yellow,green} one-hot lamps, street A
//   street_b   out  {red,yellow,green} one-hot lamps, street B
//   walk_a     out  walk lamp, crossing A
//   walk_b     out  walk lamp, crossing B
//   remain     out  seconds left in the current phase
//   phase      out  state code ARA=0 AG=1 AY=2 ARB=3 BG=4 BY=5
//   emg_active out  current green is being held by an emergency

module traffic_phase_arbiter #(
    parameter int unsigned T_GREEN     = 25,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_MIN_GREEN = 8,
    parameter int unsigned T_WALK      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req_a,
    input  logic       ped_req_b,
    input  logic       emg_a,
    input  logic       emg_b,
    output logic [2:0] street_a,
    output logic [2:0] street_b,
    output logic       walk_a,
    output logic       walk_b,
    output logic [7:0] remain,
    output logic [2:0] phase,
    output logic       emg_active
);

    typedef enum logic [2:0] {
        ST_ARA = 3'd0,
        ST_AG  = 3'd1,
        ST_AY  = 3'd2,
        ST_ARB = 3'd3,
        ST_BG  = 3'd4,
        ST_BY  = 3'd5
    } state_t;

    localparam logic [7:0] GREEN_TIME  = 8'(T_GREEN);
    localparam logic [7:0] YELLOW_TIME = 8'(T_YELLOW);
    localparam logic [7:0] ALLRED_TIME = 8'(T_ALLRED);
    localparam logic [7:0] WALK_TIME   = 8'(T_WALK);
    // A green may be cut short once remain has fallen to this value,
    // i.e. after T_MIN_GREEN ticks of green have been shown.
    localparam logic [7:0] EARLY_LIMIT = 8'(T_GREEN - T_MIN_GREEN + 1);

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_remain;
    logic [7:0] w_next_remain;
    logic       r_pend_a;
    logic       r_pend_b;
    logic       r_walk_a;
    logic       r_walk_b;
    logic [7:0] r_walk_cnt_a;
    logic [7:0] r_walk_cnt_b;
    logic [2:0] r_street_a;
    logic [2:0] r_street_b;
    logic       r_emg_active;

    logic       w_emg_any;
    logic       w_last;
    logic       w_early_a;
    logic       w_early_b;
    logic       w_enter_ag;
    logic       w_enter_bg;
    logic       w_serve_a;
    logic       w_serve_b;
    logic       w_hold_next;

    function automatic logic [2:0] lamp_a(input state_t s);
        case (s)
            ST_AG:   lamp_a = LAMP_GREEN;
            ST_AY:   lamp_a = LAMP_YELLOW;
            default: lamp_a = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input state_t s);
        case (s)
            ST_BG:   lamp_b = LAMP_GREEN;
            ST_BY:   lamp_b = LAMP_YELLOW;
            default: lamp_b = LAMP_RED;
        endcase
    endfunction

    assign w_emg_any = emg_a | emg_b;
    assign w_last    = (r_remain == 8'd1);
    // Pedestrians waiting to cross A shorten A's green, and vice versa.
    assign w_early_a = r_pend_a && !w_emg_any && (r_remain <= EARLY_LIMIT);
    assign w_early_b = r_pend_b && !w_emg_any && (r_remain <= EARLY_LIMIT);

    always_comb begin
        w_next_state  = r_state;
        w_next_remain = r_remain;
        if (tick) begin
            case (r_state)
                ST_ARA, ST_ARB: begin
                    if (w_last) begin
                        w_next_remain = GREEN_TIME;
                        if (emg_a) begin
                            w_next_state = ST_AG;
                        end else if (emg_b) begin
                            w_next_state = ST_BG;
                        end else if (r_state == ST_ARA) begin
                            w_next_state = ST_AG;
                        end else begin
                            w_next_state = ST_BG;
                        end
                    end else begin
                        w_next_remain = r_remain - 8'd1;
                    end
                end
                ST_AG: begin
                    if (emg_a) begin
                        // Held green: countdown frozen until release.
                        w_next_remain = r_remain;
                    end else if (emg_b || w_early_a || w_last) begin
                        w_next_state  = ST_AY;
                        w_next_remain = YELLOW_TIME;
                    end else begin
                        w_next_remain = r_remain - 8'd1;
                    end
                end
                ST_AY: begin
                    if (w_last) begin
                        w_next_state  = ST_ARB;
                        w_next_remain = ALLRED_TIME;
                    end else begin
                        w_next_remain = r_remain - 8'd1;
                    end
                end
                ST_BG: begin
                    if (emg_a) begin
                        w_next_state  = ST_BY;
                        w_next_remain = YELLOW_TIME;
                    end else if (emg_b) begin
                        w_next_remain = r_remain;
                    end else if (w_early_b || w_last) begin
                        w_next_state  = ST_BY;
                        w_next_remain = YELLOW_TIME;
                    end else begin
                        w_next_remain = r_remain - 8'd1;
                    end
                end
                ST_BY: begin
                    if (w_last) begin
                        w_next_state  = ST_ARA;
                        w_next_remain = ALLRED_TIME;
                    end else begin
                        w_next_remain = r_remain - 8'd1;
                    end
                end
                default: begin
                    w_next_state  = ST_ARA;
                    w_next_remain = ALLRED_TIME;
                end
            endcase
        end
    end

    assign w_enter_ag = (w_next_state == ST_AG) && (r_state != ST_AG);
    assign w_enter_bg = (w_next_state == ST_BG) && (r_state != ST_BG);
    // A request pulse arriving on the entry cycle is served directly.
    assign w_serve_b  = w_enter_ag && !w_emg_any && (r_pend_b || ped_req_b);
    assign w_serve_a  = w_enter_bg && !w_emg_any && (r_pend_a || ped_req_a);
    assign w_hold_next = ((w_next_state == ST_AG) && emg_a) ||
                         ((w_next_state == ST_BG) && emg_b && !emg_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ARA;
            r_remain     <= ALLRED_TIME;
            r_street_a   <= LAMP_RED;
            r_street_b   <= LAMP_RED;
            r_emg_active <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_remain     <= w_next_remain;
            r_street_a   <= lamp_a(w_next_state);
            r_street_b   <= lamp_b(w_next_state);
            r_emg_active <= w_hold_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
        end else begin
            r_pend_a <= w_serve_a ? 1'b0 : (r_pend_a | ped_req_a);
            r_pend_b <= w_serve_b ? 1'b0 : (r_pend_b | ped_req_b);
        end
    end

    // Walk lamps time out on their own tick count, independent of the phase
    // countdown; any emergency kills them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_walk_a     <= 1'b0;
            r_walk_cnt_a <= 8'd0;
        end else if (w_emg_any) begin
            r_walk_a     <= 1'b0;
            r_walk_cnt_a <= 8'd0;
        end else if (w_serve_a) begin
            r_walk_a     <= 1'b1;
            r_walk_cnt_a <= WALK_TIME;
        end else if (tick && r_walk_a) begin
            if (r_walk_cnt_a == 8'd1) begin
                r_walk_a <= 1'b0;
            end
            r_walk_cnt_a <= r_walk_cnt_a - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_walk_b     <= 1'b0;
            r_walk_cnt_b <= 8'd0;
        end else if (w_emg_any) begin
            r_walk_b     <= 1'b0;
            r_walk_cnt_b <= 8'd0;
        end else if (w_serve_b) begin
            r_walk_b     <= 1'b1;
            r_walk_cnt_b <= WALK_TIME;
        end else if (tick && r_walk_b) begin
            if (r_walk_cnt_b == 8'd1) begin
                r_walk_b <= 1'b0;
            end
            r_walk_cnt_b <= r_walk_cnt_b - 8'd1;
        end
    end

    assign street_a   = r_street_a;
    assign street_b   = r_street_b;
    assign walk_a     = r_walk_a;
    assign walk_b     = r_walk_b;
    assign remain     = r_remain;
    assign phase      = r_state;
    assign emg_active = r_emg_active;

endmodule
